cp0_regfile: RTL and testbench

Coprocessor-0 register bank (Status, Cause, EPC) that answers the exception/eret/mtc0 write requests produced by the decode stage and returns the current register values to it. Also samples external interrupt lines, latches pending bits in Cause.IP and runs a request/acknowledge handshake with the fetch/pipeline control so asynchronous interrupts enter the handler at HANDLER_ADDR. Sits beside the decode unit, clocked with the CPU core.

---
 rtl/cp0_regfile_if.sv | 50 +++++
 rtl/cp0_regfile.sv | 147 ++++++++++++++
 tb/tb_cp0_regfile.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cp0_regfile_if.sv
// Decode/pipeline-control side bus of the CP0 register bank.
// Timer signals exist only when CP0_TIMER_EN is defined.
interface cp0_regfile_if;
`ifdef CP0_TIMER_EN
    logic        Compare_write;
    logic [31:0] Compare_write_data;
    logic [31:0] Count_read_data;
    logic [31:0] Compare_read_data;
`endif
    logic        Status_write;
    logic [31:0] Status_write_data;
    logic        Cause_write;
    logic [31:0] Cause_write_data;
    logic        EPC_write;
    logic [31:0] EPC_write_data;
    logic [31:0] Status_read_data;
    logic [31:0] Cause_read_data;
    logic [31:0] EPC_read_data;
    logic [5:0]  Interrupt_in;
    logic [31:0] PC_interrupted;
    logic        Interrupt_request;
    logic        Interrupt_ack;
    logic [31:0] PC_interrupt;

    modport master (
`ifdef CP0_TIMER_EN
        output Compare_write, Compare_write_data,
        input  Count_read_data, Compare_read_data,
`endif
        output Status_write, Status_write_data,
        output Cause_write, Cause_write_data,
        output EPC_write, EPC_write_data,
        input  Status_read_data, Cause_read_data, EPC_read_data,
        output Interrupt_in, PC_interrupted, Interrupt_ack,
        input  Interrupt_request, PC_interrupt
    );

    modport slave (
`ifdef CP0_TIMER_EN
        input  Compare_write, Compare_write_data,
        output Count_read_data, Compare_read_data,
`endif
        input  Status_write, Status_write_data,
        input  Cause_write, Cause_write_data,
        input  EPC_write, EPC_write_data,
        output Status_read_data, Cause_read_data, EPC_read_data,
        input  Interrupt_in, PC_interrupted, Interrupt_ack,
        output Interrupt_request, PC_interrupt
    );
endinterface

// File: rtl/cp0_regfile.sv
// CP0 Status/Cause/EPC bank with synchronized external interrupts and a request/ack handshake.
// Optional Count/Compare timer on IP[15] is built when CP0_TIMER_EN is defined.
module cp0_regfile #(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000F000,
    parameter int          SYNC_STAGES  = 2,
    parameter logic [31:0] STATUS_RESET = 32'h0000FF01
) (
    input logic          clock,
    input logic          reset,
    cp0_regfile_if.slave bus
);
    typedef enum logic [1:0] {IDLE, REQUEST, SERVICE} state_e;

    localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [31:0] status_q, status_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] epc_q, epc_d;
    logic [SYNC_N-1:0][5:0] sync_q, sync_d;
    logic [5:0]  line_prev_q, line_prev_d;
    state_e      state_q, state_d;

    logic [5:0]  edges;
    logic [5:0]  hw_set;
    logic [5:0]  ip_hw_keep;
    logic        any_write;
    logic        compare_clr;
    logic        pend;
    logic        take_irq;
    logic        request;

    // Sync chain shifts toward the top index; edge detection uses one extra flop.
    always_comb begin
        sync_d      = {sync_q[SYNC_N-2:0], bus.Interrupt_in};
        line_prev_d = sync_q[SYNC_N-1];
    end

    assign edges = sync_q[SYNC_N-1] & ~line_prev_q;

`ifdef CP0_TIMER_EN
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        timer_hit;

    always_comb begin
        count_d   = count_q + 32'd1;
        compare_d = bus.Compare_write ? bus.Compare_write_data : compare_q;
    end

    assign timer_hit   = (count_q == compare_q) && (compare_q != 32'd0);
    assign hw_set      = edges | {timer_hit, 5'd0};
    assign compare_clr = bus.Compare_write;
    assign any_write   = bus.Status_write | bus.Cause_write | bus.EPC_write | bus.Compare_write;

    assign bus.Count_read_data   = count_q;
    assign bus.Compare_read_data = compare_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q   <= 32'd0;
            compare_q <= 32'd0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
        end
    end
`else
    assign hw_set      = edges;
    assign compare_clr = 1'b0;
    assign any_write   = bus.Status_write | bus.Cause_write | bus.EPC_write;
`endif

    assign pend = status_q[0] & (|(cause_q[15:8] & status_q[15:8]));

    always_comb begin
        state_d  = state_q;
        take_irq = 1'b0;
        request  = 1'b0;
        case (state_q)
            IDLE: begin
                if (pend) state_d = REQUEST;
            end
            REQUEST: begin
                request = 1'b1;
                // A decode write in the ack cycle is a synchronous exception and wins.
                if (bus.Interrupt_ack) begin
                    if (any_write) begin
                        state_d = IDLE;
                    end else begin
                        take_irq = 1'b1;
                        state_d  = SERVICE;
                    end
                end else if (!pend) begin
                    state_d = IDLE;
                end
            end
            SERVICE: begin
                if (status_q[0]) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        status_d   = status_q;
        cause_d    = cause_q;
        epc_d      = epc_q;
        ip_hw_keep = cause_q[15:10] & ~{compare_clr, 5'd0};
        if (bus.Status_write) status_d = bus.Status_write_data;
        if (bus.EPC_write)    epc_d    = bus.EPC_write_data;
        if (bus.Cause_write) begin
            cause_d    = bus.Cause_write_data;
            ip_hw_keep = ip_hw_keep & bus.Cause_write_data[15:10];
        end
        if (take_irq) begin
            epc_d       = bus.PC_interrupted;
            cause_d[6:2] = 5'd0;
            status_d[0] = 1'b0;
        end
        // Software can only clear hardware pending bits; a new edge always sets.
        cause_d[15:10] = ip_hw_keep | hw_set;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            status_q    <= STATUS_RESET;
            cause_q     <= 32'd0;
            epc_q       <= 32'd0;
            sync_q      <= '0;
            line_prev_q <= 6'd0;
            state_q     <= IDLE;
        end else begin
            status_q    <= status_d;
            cause_q     <= cause_d;
            epc_q       <= epc_d;
            sync_q      <= sync_d;
            line_prev_q <= line_prev_d;
            state_q     <= state_d;
        end
    end

    assign bus.Status_read_data  = status_q;
    assign bus.Cause_read_data   = cause_q;
    assign bus.EPC_read_data     = epc_q;
    assign bus.Interrupt_request = request;
    assign bus.PC_interrupt      = request ? HANDLER_ADDR : 32'hFFFFFFFF;
endmodule

// File: tb/tb_cp0_regfile.sv
// Scoreboard bench for cp0_regfile: driver pushes model expectations, monitor compares each cycle.
module tb_cp0_regfile;
    localparam logic [31:0] HANDLER = 32'h0000F000;
    localparam logic [31:0] ST_RST  = 32'h0000FF01;
    localparam int          SYNC    = 2;

    logic clock = 1'b0;
    logic reset = 1'b0;
    cp0_regfile_if cif();

    cp0_regfile #(
        .HANDLER_ADDR(HANDLER),
        .SYNC_STAGES (SYNC),
        .STATUS_RESET(ST_RST)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (cif)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          tgt;
        logic [31:0] st;
        logic [31:0] ca;
        logic [31:0] ep;
        logic        req;
        logic [31:0] pci;
    } exp_t;

    typedef struct {
        logic        sw;
        logic [31:0] sd;
        logic        cw;
        logic [31:0] cd;
        logic        ew;
        logic [31:0] ed;
        logic [5:0]  intr;
        logic        ack;
        logic [31:0] pc;
    } stim_t;

    exp_t  sb[$];
    stim_t nx;
    int    cyc = 0;
    int    n_chk = 0;
    int    n_err = 0;

    // Reference model: architectural registers, handshake phase and input history
    logic [31:0] m_st, m_ca, m_ep;
    bit          m_req, m_svc;
    logic [5:0]  hq[$];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %h, expected %h", nm, cyc, act, exp);
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].tgt < cyc) begin
            e = sb.pop_front();
            n_chk++;
            n_err++;
            $display("FAIL stale_entry: expectation for cycle %0d unchecked at cycle %0d", e.tgt, cyc);
        end
        if (sb.size() > 0 && sb[0].tgt == cyc) begin
            e = sb.pop_front();
            chk("status", cif.Status_read_data, e.st);
            chk("cause", cif.Cause_read_data, e.ca);
            chk("epc", cif.EPC_read_data, e.ep);
            chk("irq_req", {31'd0, cif.Interrupt_request}, {31'd0, e.req});
            chk("pc_int", cif.PC_interrupt, e.pci);
        end
    end

    task automatic clear_nx();
        nx.sw  = 1'b0; nx.sd = 32'd0;
        nx.cw  = 1'b0; nx.cd = 32'd0;
        nx.ew  = 1'b0; nx.ed = 32'd0;
        nx.ack = 1'b0; nx.pc = 32'd0;
    endtask

    task automatic tick(input bit rstp);
        exp_t        e;
        logic [5:0]  edg, ip_hw;
        logic [31:0] n_st, n_ca, n_ep;
        bit          pend, anyw, take;
        @(posedge clock);
        #1;
        reset                  = 1'b1;
        cif.Status_write       = nx.sw;
        cif.Status_write_data  = nx.sd;
        cif.Cause_write        = nx.cw;
        cif.Cause_write_data   = nx.cd;
        cif.EPC_write          = nx.ew;
        cif.EPC_write_data     = nx.ed;
        cif.Interrupt_in       = nx.intr;
        cif.Interrupt_ack      = nx.ack;
        cif.PC_interrupted     = nx.pc;
        if (rstp) begin
            m_st = ST_RST; m_ca = 32'd0; m_ep = 32'd0;
            m_req = 1'b0; m_svc = 1'b0;
            hq.delete();
            repeat (SYNC + 2) hq.push_back(6'd0);
        end else begin
            hq.push_front(nx.intr);
            void'(hq.pop_back());
            edg  = hq[SYNC] & ~hq[SYNC+1];
            pend = m_st[0] && ((m_ca[15:8] & m_st[15:8]) != 8'd0);
            anyw = nx.sw || nx.cw || nx.ew;
            take = m_req && nx.ack && !anyw;
            n_st = nx.sw ? nx.sd : m_st;
            n_ep = nx.ew ? nx.ed : m_ep;
            n_ca = nx.cw ? nx.cd : m_ca;
            ip_hw = nx.cw ? (m_ca[15:10] & nx.cd[15:10]) : m_ca[15:10];
            n_ca[15:10] = ip_hw | edg;
            if (take) begin
                n_ep = nx.pc;
                n_ca[6:2] = 5'd0;
                n_st[0] = 1'b0;
            end
            if (m_req) begin
                if (nx.ack) begin
                    m_req = 1'b0;
                    m_svc = !anyw;
                end else if (!pend) begin
                    m_req = 1'b0;
                end
            end else if (m_svc) begin
                if (m_st[0]) m_svc = 1'b0;
            end else if (pend) begin
                m_req = 1'b1;
            end
            m_st = n_st; m_ca = n_ca; m_ep = n_ep;
        end
        e.tgt = cyc + 1;
        e.st  = m_st;
        e.ca  = m_ca;
        e.ep  = m_ep;
        e.req = m_req;
        e.pci = m_req ? HANDLER : 32'hFFFFFFFF;
        sb.push_back(e);
        clear_nx();
        if (rstp) begin
            @(negedge clock);
            #1;
            reset = 1'b0;
        end
    endtask

    task automatic wait_req();
        for (int i = 0; i < 12 && !m_req; i++) tick(1'b0);
    endtask

    task automatic pulse(input int bitn);
        nx.intr[bitn] = 1'b1;
        repeat (3) tick(1'b0);
        nx.intr[bitn] = 1'b0;
    endtask

    initial begin
        clear_nx();
        nx.intr = 6'd0;
        cif.Status_write = 1'b0; cif.Status_write_data = 32'd0;
        cif.Cause_write = 1'b0;  cif.Cause_write_data = 32'd0;
        cif.EPC_write = 1'b0;    cif.EPC_write_data = 32'd0;
        cif.Interrupt_in = 6'd0; cif.Interrupt_ack = 1'b0;
        cif.PC_interrupted = 32'd0;

        tick(1'b1);
        tick(1'b1);
        tick(1'b0);

        // Simultaneous register writes
        nx.cw = 1'b1; nx.cd = 32'h00000024;
        nx.sw = 1'b1; nx.sd = 32'h0000FF00;
        nx.ew = 1'b1; nx.ed = 32'h00000104;
        tick(1'b0);
        tick(1'b0);
        nx.sw = 1'b1; nx.sd = ST_RST; nx.cw = 1'b1; nx.cd = 32'd0;
        tick(1'b0);

        // Full interrupt entry and return
        pulse(0);
        wait_req();
        nx.ack = 1'b1; nx.pc = 32'h00000200;
        tick(1'b0);
        repeat (2) tick(1'b0);
        nx.cw = 1'b1; nx.cd = 32'd0;
        tick(1'b0);
        nx.sw = 1'b1; nx.sd = ST_RST;
        tick(1'b0);
        repeat (3) tick(1'b0);

        // Pending interrupt masked before ack
        pulse(0);
        wait_req();
        nx.sw = 1'b1; nx.sd = 32'h0000FB01;
        tick(1'b0);
        repeat (3) tick(1'b0);
        nx.cw = 1'b1; nx.cd = 32'd0; nx.sw = 1'b1; nx.sd = 32'h0000FF00;
        tick(1'b0);

        // Software clear colliding with a fresh hardware edge
        nx.intr[0] = 1'b1;
        tick(1'b0);
        tick(1'b0);
        nx.cw = 1'b1; nx.cd = 32'd0;
        tick(1'b0);
        nx.intr[0] = 1'b0;
        repeat (2) tick(1'b0);

        // Ack coincident with a synchronous exception
        nx.sw = 1'b1; nx.sd = ST_RST;
        tick(1'b0);
        pulse(1);
        wait_req();
        nx.cw = 1'b1; nx.cd = 32'h00000020;
        nx.ew = 1'b1; nx.ed = 32'h00000300;
        nx.ack = 1'b1; nx.pc = 32'h00000400;
        tick(1'b0);
        repeat (3) tick(1'b0);

        // Reset in the middle of a handshake
        pulse(2);
        wait_req();
        tick(1'b1);
        repeat (3) tick(1'b0);

        for (int i = 0; i < 500; i++) begin
            nx.sw = ($urandom_range(0, 15) == 0);
            nx.sd = $urandom;
            nx.sd[0] = ($urandom_range(0, 3) != 0);
            nx.cw = ($urandom_range(0, 11) == 0);
            nx.cd = $urandom;
            nx.ew = ($urandom_range(0, 15) == 0);
            nx.ed = $urandom;
            nx.ack = ($urandom_range(0, 2) == 0);
            nx.pc = $urandom;
            if ($urandom_range(0, 3) == 0) nx.intr[$urandom_range(0, 5)] ^= 1'b1;
            tick($urandom_range(0, 149) == 0);
        end

        for (int i = 0; i < 6 && sb.size() > 0; i++) @(negedge clock);
        #1;
        if (sb.size() > 0) begin
            n_chk++;
            n_err++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
